// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and GF(2^8) helpers for the key schedule.
package aes_pkg;

    localparam int unsigned NB    = 128;
    localparam int unsigned NR    = 10;
    localparam int unsigned ZERO  = 0;
    localparam int unsigned IDX_W = 4;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_state_e;

    // Round key viewed as four big-endian words, w0 in the top bits.
    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } rkey_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_sched_if.sv
// Key-load / round-key handshake bundle between the controller and the key schedule.
interface aes128_key_sched_if
    import aes_pkg::*;
();

    logic [NB-1:0]    key_in;
    logic             key_load;
    logic [NB-1:0]    rk_out;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_valid;
    logic             rk_ready;
    logic             busy;
    logic             done;

    modport master (
        output key_in, key_load, rk_ready,
        input  rk_out, rk_idx, rk_valid, busy, done
    );

    modport slave (
        input  key_in, key_load, rk_ready,
        output rk_out, rk_idx, rk_valid, busy, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_c
);

    // Row-major table, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_c = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: emits round keys 0..10, one per accepted handshake,
// deriving each key from the previous one rather than storing the full schedule.
module aes128_key_sched
    import aes_pkg::*;
(
    input logic               Clk,
    input logic               Rst_n,
    aes128_key_sched_if.slave bus
);

    ks_state_e        state_q, state_d;
    rkey_t            rk_q, rk_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] n0, n1, n2, n3;

    // RotWord then SubWord on the last word of the current key.
    assign rot_w = {rk_q.w3[23:0], rk_q.w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte (rot_w[8*i +: 8]),
            .out_c   (sub_w[8*i +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon_q, 24'h000000};
    assign n0  = rk_q.w0 ^ t_w;
    assign n1  = rk_q.w1 ^ n0;
    assign n2  = rk_q.w2 ^ n1;
    assign n3  = rk_q.w3 ^ n2;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.key_load) begin
                    rk_d    = bus.key_in;
                    idx_d   = IDX_W'(ZERO);
                    rcon_d  = RCON_INIT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (valid_q && bus.rk_ready) begin
                    if (idx_q == IDX_W'(NR)) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rk_d   = {n0, n1, n2, n3};
                        idx_d  = idx_q + IDX_W'(1);
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= IDX_W'(ZERO);
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rk_out   = rk_q;
    assign bus.rk_idx   = idx_q;
    assign bus.rk_valid = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_key_sched.sv
// Self-checking bench for aes128_key_sched against a word-level FIPS-197 expansion model.
module tb_aes128_key_sched;
    import aes_pkg::*;

    localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_A10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_B10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [7:0]   RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    aes128_key_sched_if bus ();

    aes128_key_sched dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_xfer  = 0;

    logic [7:0]   sb     [256];
    logic [127:0] m_keys [11];
    logic [127:0] cap    [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Textbook 44-word expansion, grouped into 11 round keys.
    task automatic load_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {RCON_TBL[i/4 - 1], 24'h000000};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Compare process: behavioural phase tracking, checked every falling edge.
    initial begin : compare
        int  phase;
        int  nxt;
        bit  fresh;
        phase = 0;
        nxt   = 0;
        fresh = 1'b1;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                chk("rst_valid", 128'(bus.rk_valid), 128'(0));
                chk("rst_busy",  128'(bus.busy),     128'(0));
                chk("rst_done",  128'(bus.done),     128'(0));
                chk("rst_idx",   128'(bus.rk_idx),   128'(0));
                chk("rst_out",   bus.rk_out,         128'(0));
                phase = 0;
                nxt   = 0;
                fresh = 1'b1;
            end else begin
                if (bus.done) n_done++;
                chk("valid", 128'(bus.rk_valid), 128'(phase == 1));
                chk("busy",  128'(bus.busy),     128'(phase == 1));
                chk("done",  128'(bus.done),     128'(phase == 2));
                if (phase == 1) begin
                    chk("rk_idx", 128'(bus.rk_idx), 128'(nxt));
                    chk("rk_out", bus.rk_out, m_keys[nxt]);
                    cap[nxt] = bus.rk_out;
                end else if (fresh) begin
                    chk("idle_idx", 128'(bus.rk_idx), 128'(0));
                    chk("idle_out", bus.rk_out, 128'(0));
                end
                case (phase)
                    0: if (bus.key_load) begin
                        load_model(bus.key_in);
                        phase = 1;
                        nxt   = 0;
                        fresh = 1'b0;
                    end
                    1: if (bus.rk_ready) begin
                        n_xfer++;
                        if (nxt == 10) phase = 2;
                        else nxt++;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 11; i++) cap[i] = 128'h0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int k = 0;
        while (!bus.done && k < budget) begin
            if (rand_ready) bus.rk_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("done_seen", 128'(bus.done), 128'(1));
        bus.rk_ready = 1'b1;
    endtask

    task automatic wait_idx(input int target, input int budget);
        int k = 0;
        while (!(bus.rk_valid && bus.rk_idx == 4'(target)) && k < budget) begin
            tick();
            k++;
        end
        chk("idx_reached", 128'(bus.rk_idx), 128'(target));
    endtask

    initial begin : stim
        int d0, x0;
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.rk_ready = 1'b0;
        build_sbox();

        // Pin the model itself to published vectors.
        chk("model_sb00", 128'(sb[0]),     128'(8'h63));
        chk("model_sb53", 128'(sb[8'h53]), 128'(8'hed));
        load_model(KEY_A);
        chk("model_a0",  m_keys[0],  KEY_A);
        chk("model_a1",  m_keys[1],  KEY_A1);
        chk("model_a10", m_keys[10], KEY_A10);
        load_model(KEY_B);
        chk("model_b1",  m_keys[1],  KEY_B1);
        chk("model_b10", m_keys[10], KEY_B10);

        // Reset then idle for 20 cycles, with rk_ready toggled on partway.
        #23 Rst_n = 1'b1;
        repeat (10) tick();
        bus.rk_ready = 1'b1;
        repeat (10) tick();

        // FIPS-197 key, ready held high, key_load coincides with rk_ready in IDLE.
        clear_cap();
        d0 = n_done;
        load(KEY_A);
        chk("a_first_idx", 128'(bus.rk_idx), 128'(0));
        wait_done(30, 1'b0);
        chk("a_rk0",  cap[0],  KEY_A);
        chk("a_rk1",  cap[1],  KEY_A1);
        chk("a_rk10", cap[10], KEY_A10);
        // key_load during the DONE cycle is ignored.
        load(KEY_B);
        repeat (3) tick();
        chk("a_done_once", 128'(n_done - d0), 128'(1));
        chk("a_no_restart", 128'(bus.rk_valid), 128'(0));

        // Second key.
        clear_cap();
        load(KEY_B);
        wait_done(30, 1'b0);
        chk("b_rk1",  cap[1],  KEY_B1);
        chk("b_rk10", cap[10], KEY_B10);
        repeat (2) tick();

        // Random backpressure.
        clear_cap();
        x0 = n_xfer;
        load(KEY_A);
        wait_done(300, 1'b1);
        chk("bp_xfers", 128'(n_xfer - x0), 128'(11));
        chk("bp_rk10", cap[10], KEY_A10);
        repeat (2) tick();

        // key_load mid-RUN is ignored.
        clear_cap();
        d0 = n_done;
        load(KEY_B);
        wait_idx(4, 20);
        load(KEY_A);
        wait_done(30, 1'b0);
        chk("ign_rk10", cap[10], KEY_B10);
        repeat (2) tick();
        chk("ign_done_once", 128'(n_done - d0), 128'(1));

        // Asynchronous reset between edges at rk_idx 6.
        load(KEY_A);
        wait_idx(6, 20);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(bus.rk_valid), 128'(0));
        chk("arst_busy",  128'(bus.busy),     128'(0));
        chk("arst_idx",   128'(bus.rk_idx),   128'(0));
        chk("arst_out",   bus.rk_out,         128'(0));
        tick();
        Rst_n = 1'b1;
        repeat (2) tick();
        clear_cap();
        load(KEY_B);
        chk("rst_restart_idx",   128'(bus.rk_idx),   128'(0));
        chk("rst_restart_valid", 128'(bus.rk_valid), 128'(1));
        wait_done(30, 1'b0);
        chk("rst_restart_rk10", cap[10], KEY_B10);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
